key_press_decoder: RTL and testbench

Input-side counterpart of the buzzer pattern generator. It takes one raw push-button line, debounces it on the shared 1 kHz tick, and classifies each press as short, long or double. Each class produces a one-cycle pulse, and these pulses drive the timer control logic (start/stop, reset, mode), including the `i_go` that starts a buzzer sequence. It sits between the board key pin and the timer FSM, in the same `i_clk` domain.

---
 rtl/key_press_decoder_pkg.sv | 31 +++
 rtl/key_press_decoder_if.sv | 38 +++
 rtl/key_press_decoder_debounce.sv | 65 ++++++
 rtl/key_press_decoder.sv | 112 +++++++++++
 tb/tb_key_press_decoder.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/key_press_decoder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : key_pkg
// Description : Shared types and default constants for the key press decoder:
//               classifier state encoding and default timing parameters.
// Revision    : 1.0  initial release
// ============================================================================
package key_pkg;

    // Classifier states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PRESS1 = 2'd1,
        GAP    = 2'd2,
        HOLD   = 2'd3
    } key_state_e;

    // Plain-vector views of the state encoding for the FSM register
    localparam logic [1:0] S_IDLE   = IDLE;
    localparam logic [1:0] S_PRESS1 = PRESS1;
    localparam logic [1:0] S_GAP    = GAP;
    localparam logic [1:0] S_HOLD   = HOLD;

    // Default timing, in 1 ms ticks
    localparam int DEF_DEBOUNCE_MS   = 20;
    localparam int DEF_LONG_MS       = 1000;
    localparam int DEF_DOUBLE_GAP_MS = 300;
    localparam int DEF_CNT_W         = 11;

endpackage : key_pkg
`default_nettype wire

// File: rtl/key_press_decoder_if.sv
`default_nettype none
// ============================================================================
// Module      : key_press_decoder_if
// Description : Tick/key inputs and debounced level / classification pulses
//               exchanged between the key front end and its user.
// Revision    : 1.0  initial release
// ============================================================================
interface key_press_decoder_if;

    logic i_pls_1k;
    logic i_key;
    logic o_pressed;
    logic o_short;
    logic o_long;
    logic o_double;

    // Driver side (board / bench)
    modport master (
        output i_pls_1k,
        output i_key,
        input  o_pressed,
        input  o_short,
        input  o_long,
        input  o_double
    );

    // Decoder side
    modport slave (
        input  i_pls_1k,
        input  i_key,
        output o_pressed,
        output o_short,
        output o_long,
        output o_double
    );

endinterface : key_press_decoder_if
`default_nettype wire

// File: rtl/key_press_decoder_debounce.sv
`default_nettype none
// ============================================================================
// Module      : key_debounce
// Description : 2-FF synchronizer, tick-based debouncer and one-cycle
//               rise/fall event generation on the debounced level.
// Revision    : 1.0  initial release
// ============================================================================
module key_debounce #(
    parameter int DEBOUNCE_MS = 20,
    parameter int CNT_W       = 11
) (
    input  wire logic i_clk,
    input  wire logic i_rst,
    input  wire logic i_tick,
    input  wire logic i_key,
    output logic      o_pressed,
    output logic      o_rise,
    output logic      o_fall
);

    logic             r_sync1;
    logic             r_key_s;
    logic             r_stable;
    logic             r_stable_d;
    logic [CNT_W-1:0] r_db_cnt;
    logic [CNT_W-1:0] w_db_inc;

    // Saturating increment so a stuck mismatch can never wrap the counter
    always_comb begin
        w_db_inc = (&r_db_cnt) ? r_db_cnt : r_db_cnt + 1'b1;
    end

    // Synchronize, debounce on ticks, and delay the stable level for edges
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1    <= 1'b0;
            r_key_s    <= 1'b0;
            r_stable   <= 1'b0;
            r_stable_d <= 1'b0;
            r_db_cnt   <= '0;
        end else begin
            r_sync1    <= i_key;
            r_key_s    <= r_sync1;
            r_stable_d <= r_stable;
            if (i_tick) begin
                if (r_key_s != r_stable) begin
                    if (w_db_inc >= CNT_W'(DEBOUNCE_MS)) begin
                        r_stable <= r_key_s;
                        r_db_cnt <= '0;
                    end else begin
                        r_db_cnt <= w_db_inc;
                    end
                end else begin
                    r_db_cnt <= '0;
                end
            end
        end
    end

    assign o_pressed = r_stable;
    assign o_rise    = r_stable & ~r_stable_d;
    assign o_fall    = ~r_stable & r_stable_d;

endmodule : key_debounce
`default_nettype wire

// File: rtl/key_press_decoder.sv
`default_nettype none
// ============================================================================
// Module      : key_press_decoder
// Description : Debounces a push-button and classifies each press sequence
//               as short, long or double, emitting one registered pulse.
// Revision    : 1.0  initial release
// ============================================================================
module key_press_decoder
    import key_pkg::*;
#(
    parameter int DEBOUNCE_MS   = DEF_DEBOUNCE_MS,
    parameter int LONG_MS       = DEF_LONG_MS,
    parameter int DOUBLE_GAP_MS = DEF_DOUBLE_GAP_MS,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  wire logic           i_clk,
    input  wire logic           i_rst,
    key_press_decoder_if.slave  kp
);

    logic             w_pressed;
    logic             w_rise;
    logic             w_fall;
    logic [CNT_W-1:0] w_cnt_inc;

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_short;
    logic             r_long;
    logic             r_double;

    key_debounce #(
        .DEBOUNCE_MS (DEBOUNCE_MS),
        .CNT_W       (CNT_W)
    ) u_debounce (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_tick    (kp.i_pls_1k),
        .i_key     (kp.i_key),
        .o_pressed (w_pressed),
        .o_rise    (w_rise),
        .o_fall    (w_fall)
    );

    // Saturating tick count for the press and gap timers
    always_comb begin
        w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + 1'b1;
    end

    // Classifier: edges are checked before thresholds so an edge wins a tie
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_short  <= 1'b0;
            r_long   <= 1'b0;
            r_double <= 1'b0;
        end else begin
            r_short  <= 1'b0;
            r_long   <= 1'b0;
            r_double <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_rise) begin
                        r_cnt   <= '0;
                        r_state <= S_PRESS1;
                    end
                end
                S_PRESS1: begin
                    if (w_fall) begin
                        r_cnt   <= '0;
                        r_state <= S_GAP;
                    end else if (kp.i_pls_1k) begin
                        r_cnt <= w_cnt_inc;
                        if (w_cnt_inc >= CNT_W'(LONG_MS)) begin
                            r_long  <= 1'b1;
                            r_state <= S_HOLD;
                        end
                    end
                end
                S_GAP: begin
                    if (w_rise) begin
                        r_double <= 1'b1;
                        r_state  <= S_HOLD;
                    end else if (kp.i_pls_1k) begin
                        r_cnt <= w_cnt_inc;
                        if (w_cnt_inc >= CNT_W'(DOUBLE_GAP_MS)) begin
                            r_short <= 1'b1;
                            r_state <= S_IDLE;
                        end
                    end
                end
                S_HOLD: begin
                    // Already classified; just wait for the release
                    if (w_fall) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign kp.o_pressed = w_pressed;
    assign kp.o_short   = r_short;
    assign kp.o_long    = r_long;
    assign kp.o_double  = r_double;

endmodule : key_press_decoder
`default_nettype wire

// File: tb/tb_key_press_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_key_press_decoder
// Description : Scoreboard bench for key_press_decoder: directed key
//               waveforms push expected pulses, a monitor pops and checks
//               kind and timing against the debounced edges and ticks.
// Revision    : 1.0  initial release
// ============================================================================
module tb_key_press_decoder;

    localparam int c_DEBOUNCE = 3;
    localparam int c_LONG     = 10;
    localparam int c_GAP      = 5;

    // Pulse kinds
    localparam logic [1:0] c_K_SHORT  = 2'd1;
    localparam logic [1:0] c_K_LONG   = 2'd2;
    localparam logic [1:0] c_K_DOUBLE = 2'd3;

    typedef struct packed {
        logic [1:0] kind;     // expected pulse kind
        logic       ref_fall; // timing reference: 1 = debounced fall, 0 = rise
        logic [7:0] n_ticks;  // ticks after reference; 0 = exactly 1 cycle after
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_rises  = 0;
    int   n_pulses = 0;

    key_press_decoder_if kp_if ();

    key_press_decoder #(
        .DEBOUNCE_MS   (c_DEBOUNCE),
        .LONG_MS       (c_LONG),
        .DOUBLE_GAP_MS (c_GAP),
        .CNT_W         (11)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .kp    (kp_if.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic cyc_n(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic key_for(input logic v, input int n);
        kp_if.i_key = v;
        cyc_n(n);
    endtask

    // 1 ms tick: one cycle high every 4 clocks
    initial begin
        kp_if.i_pls_1k = 1'b0;
        forever begin
            @(posedge clk); #1; kp_if.i_pls_1k = 1'b1;
            @(posedge clk); #1; kp_if.i_pls_1k = 1'b0;
            repeat (2) @(posedge clk);
        end
    end

    // Monitor: pop and compare on every output pulse
    initial begin
        int   cyc;
        int   rise_cyc;
        int   fall_cyc;
        int   last_tick_cyc;
        int   ticks_rise;
        int   ticks_fall;
        int   npulse;
        logic prev_pressed;
        logic [1:0] act_kind;
        int   act_time;
        int   act_gap;
        exp_t e;
        cyc = 0; rise_cyc = 0; fall_cyc = 0; last_tick_cyc = 0;
        ticks_rise = 0; ticks_fall = 0; prev_pressed = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            npulse = int'(kp_if.o_short) + int'(kp_if.o_long) + int'(kp_if.o_double);
            if (npulse != 0) begin
                n_pulses++;
                check("pulses_per_cycle", npulse, 1);
                act_kind = kp_if.o_short ? c_K_SHORT : (kp_if.o_long ? c_K_LONG : c_K_DOUBLE);
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_pulse: got kind %0d at cycle %0d, required none", act_kind, cyc);
                end else begin
                    e = sb.pop_front();
                    if (e.n_ticks == 0) begin
                        act_time = cyc - (e.ref_fall ? fall_cyc : rise_cyc);
                        act_gap  = 1;
                    end else begin
                        act_time = e.ref_fall ? ticks_fall : ticks_rise;
                        act_gap  = cyc - last_tick_cyc;
                    end
                    n_checks++;
                    if (act_kind != e.kind || act_gap != 1 ||
                        act_time != ((e.n_ticks == 0) ? 1 : int'(e.n_ticks))) begin
                        n_fail++;
                        $display("FAIL pulse_kind_timing: got kind %0d time %0d gap %0d, required kind %0d time %0d gap 1",
                                 act_kind, act_time, act_gap, e.kind,
                                 (e.n_ticks == 0) ? 1 : int'(e.n_ticks));
                    end
                end
            end
            if (kp_if.o_pressed && !prev_pressed) begin
                rise_cyc   = cyc;
                ticks_rise = 0;
                n_rises++;
            end
            if (!kp_if.o_pressed && prev_pressed) begin
                fall_cyc   = cyc;
                ticks_fall = 0;
            end
            prev_pressed = kp_if.o_pressed;
            if (kp_if.i_pls_1k) begin
                ticks_rise++;
                ticks_fall++;
                last_tick_cyc = cyc;
            end
        end
    end

    // Stimulus
    initial begin
        int r0;
        int p0;
        int waited;
        kp_if.i_key = 1'b0;
        rst = 1'b1;
        cyc_n(2);
        rst = 1'b0;
        check("reset_outputs_at_release",
              int'({kp_if.o_pressed, kp_if.o_short, kp_if.o_long, kp_if.o_double}), 0);
        for (int i = 0; i < 10; i++) begin
            cyc_n(20);
            check("reset_outputs_idle",
                  int'({kp_if.o_pressed, kp_if.o_short, kp_if.o_long, kp_if.o_double}), 0);
        end

        // Glitch: two ticks of key, below the debounce count
        r0 = n_rises;
        p0 = n_pulses;
        key_for(1'b1, 8);
        key_for(1'b0, 60);
        check("glitch_no_rise", n_rises - r0, 0);
        check("glitch_no_pulse", n_pulses - p0, 0);

        // Short press: one o_short, 5 ticks after debounced release
        sb.push_back('{kind: c_K_SHORT, ref_fall: 1'b1, n_ticks: 8'(c_GAP)});
        key_for(1'b1, 24);
        check("short_pressed_high", int'(kp_if.o_pressed), 1);
        key_for(1'b0, 120);
        check("short_pressed_low", int'(kp_if.o_pressed), 0);
        check("short_sb_drained", sb.size(), 0);

        // Long press: o_long at the 10th tick after rise, nothing on release
        p0 = n_pulses;
        sb.push_back('{kind: c_K_LONG, ref_fall: 1'b0, n_ticks: 8'(c_LONG)});
        key_for(1'b1, 60);
        check("long_pressed_high", int'(kp_if.o_pressed), 1);
        key_for(1'b0, 120);
        check("long_sb_drained", sb.size(), 0);
        check("long_single_pulse", n_pulses - p0, 1);

        // Double press: o_double 1 cycle after second rise, no o_long in hold
        p0 = n_pulses;
        sb.push_back('{kind: c_K_DOUBLE, ref_fall: 1'b0, n_ticks: 8'd0});
        key_for(1'b1, 16);
        key_for(1'b0, 16);
        key_for(1'b1, 80);
        key_for(1'b0, 120);
        check("double_sb_drained", sb.size(), 0);
        check("double_single_pulse", n_pulses - p0, 1);

        // Reset two ticks into the gap discards the pending short
        p0 = n_pulses;
        key_for(1'b1, 24);
        kp_if.i_key = 1'b0;
        waited = 0;
        while (kp_if.o_pressed && waited < 100) begin
            cyc_n(1);
            waited++;
        end
        check("gap_release_seen", int'(kp_if.o_pressed), 0);
        cyc_n(8);
        rst = 1'b1;
        cyc_n(1);
        rst = 1'b0;
        cyc_n(120);
        check("gap_reset_no_pulse", n_pulses - p0, 0);

        // Back in IDLE: a fresh short press classifies normally
        sb.push_back('{kind: c_K_SHORT, ref_fall: 1'b1, n_ticks: 8'(c_GAP)});
        key_for(1'b1, 24);
        key_for(1'b0, 120);
        check("post_reset_sb_drained", sb.size(), 0);
        check("post_reset_single_pulse", n_pulses - p0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_key_press_decoder
`default_nettype wire
